pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel PWM generator: one shared timebase drives CHANNELS independent compare outputs with a programmable period. It supports edge-aligned and center-aligned modes. All period, compare and mode updates are double-buffered and take effect only at a period boundary, so outputs never glitch. It is the drop-in replacement for single-channel PWM instances on the register-write bus and sits between the config write port and the output pins.

## Interface

- CHANNELS, 4, number of PWM outputs (1..16)
- WIDTH, 8, counter/compare/period width in bits
- ADDR_W, $clog2(CHANNELS+1), write address width (derived; not overridden)

- sys_clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- clk_in  in  1  count-enable tick, already synchronous to sys_clk; level-sampled
- use_sys  in  1  1: count every sys_clk cycle; 0: count only when clk_in=1
- wr  in  1  write strobe; rising edge (0→1 across cycles) performs exactly one write
- wr_addr  in  ADDR_W  0..CHANNELS-1 = compare shadow of channel n; CHANNELS = period shadow; others ignored
- wr_data  in  WIDTH  write data
- center  in  1  mode request (0 edge, 1 center); sampled into active mode at boundary
- ena  in  CHANNELS  per-channel enable, not buffered
- pwm_out  out  CHANNELS  registered PWM outputs
- period_end  out  1  one-cycle pulse on each boundary

## Operation

- tick = use_sys | clk_in; counter and direction change only on tick.
- Edge mode: counter 0..period_act, up; on a tick at period_act, counter→0 and a boundary occurs.
- Center mode: up to period_act, then down to 0. On a tick at period_act, dir→down and counter→period_act-1. On a tick at 0 with dir=down, dir→up, counter→1, and a boundary occurs. Period cycle = 2·period_act ticks.
- period_act=0, either mode: counter stays 0; every tick is a boundary.
- Boundary: cmp_act[n]←cmp_shd[n] for all n, period_act←period_shd, mode_act←center, period_end=1 next cycle. If mode changes, counter→0 and dir→up.
- Write: cycle where wr=1 and wr_q=0 loads wr_data into the shadow selected by wr_addr. wr held high produces no further writes. A write coinciding with a boundary updates the shadow; active takes the old shadow and the new value applies at the following boundary.
- Output: pwm_out[n] ← ena[n] & (counter < cmp_act[n]), using unsigned WIDTH-bit compare. cmp_act=0 gives constant low. cmp_act>period_act gives constant high (100%), with no special case.
- ena low forces pwm_out low on the next cycle, regardless of boundary.
- Reset (any time, including mid-period): counter 0, dir up, mode_act edge, cmp_shd/cmp_act 0, period_shd/period_act all-ones, wr_q 0, pwm_out 0, period_end 0.

## Timing

- pwm_out has 1-cycle latency from counter state/ena; no combinational paths from inputs to outputs.
- A write is visible in the shadow 1 cycle after the wr rising edge. It reaches active at the next boundary. The output reflects it 1 cycle later.
- period_end asserts in the cycle after the boundary tick, for exactly 1 cycle; with use_sys=1 and period_act=0 it is high continuously.
- The first pwm_out reflecting a new cmp_act appears the cycle after period_end rises.

## Structure

- pwm_pkg:
  - mode enum (PWM_EDGE, PWM_CENTER)
  - address-decode constant for the period slot (ADDR_PERIOD = CHANNELS)
- Sub-module pwm_timebase: counter, dir, mode_act, period register pair, boundary/period_end generation. Outputs counter and a boundary strobe.
- Top pwm_multi: write edge detect, shadow/active compare arrays, generate loop of per-channel comparators.

## Test plan

- Reset with use_sys=1, no writes: pwm_out=0 throughout. period_end pulses every 256 cycles (period all-ones).
- Write period=9, cmp[0]=3, ena=1, use_sys=1: after first boundary, ch0 is high 3 of every 10 cycles and period_end repeats every 10 cycles.
- Write cmp[0]=7 while counter=5: duty stays 3/10 until the next boundary, then becomes 7/10 starting the cycle after period_end.
- cmp[1]=10 with period 9 → ch1 constantly high. cmp[2]=0 → ch2 constantly low. ena[1] dropped mid-period → ch1 low on the next cycle.
- center=1, period=4, cmp[0]=2: after boundary, counter sequence is 0,1,2,3,4,3,2,1 repeating. ch0 is high 3 of 8 cycles and period_end repeats every 8 cycles.
- use_sys=0, clk_in high every 4th cycle: counter advances only on those cycles. wr held high 5 cycles with changing wr_data: only the first-cycle value is captured.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM block.
// Mode encoding and the write-address slot used for the period shadow.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam int DEF_CHANNELS = 4;
    localparam int ADDR_PERIOD  = DEF_CHANNELS;

    // The period slot always sits right after the last compare slot.
    function automatic int period_addr(input int channels);
        return channels;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: counter, direction, active mode and period pair.
// Raises a boundary strobe on the wrapping tick and a registered period_end.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             center,
    input  logic             period_wr,
    input  logic [WIDTH-1:0] period_data,
    output logic [WIDTH-1:0] counter,
    output logic             boundary,
    output logic             period_end
);

    logic             dir_down;
    pwm_mode_e        mode_act;
    pwm_mode_e        mode_nxt;
    logic [WIDTH-1:0] period_shd;
    logic [WIDTH-1:0] period_act;
    logic [WIDTH-1:0] cnt_nxt;
    logic             dir_nxt;
    logic             p_zero;
    logic             is_edge;
    logic             at_top;
    logic             at_bot;

    assign p_zero  = (period_act == '0);
    assign is_edge = (mode_act == PWM_EDGE);
    assign at_top  = (counter >= period_act);
    assign at_bot  = (counter == '0);

    always_comb begin
        boundary = 1'b0;
        cnt_nxt  = counter;
        dir_nxt  = dir_down;
        mode_nxt = center ? PWM_CENTER : PWM_EDGE;
        if (tick) begin
            unique case (1'b1)
                p_zero: begin
                    boundary = 1'b1;
                    cnt_nxt  = '0;
                    dir_nxt  = 1'b0;
                end
                !p_zero && is_edge && at_top: begin
                    boundary = 1'b1;
                    cnt_nxt  = '0;
                end
                !p_zero && is_edge && !at_top: begin
                    cnt_nxt = counter + 1'b1;
                end
                !p_zero && !is_edge && dir_down && at_bot: begin
                    boundary = 1'b1;
                    dir_nxt  = 1'b0;
                    cnt_nxt  = WIDTH'(1);
                end
                !p_zero && !is_edge && dir_down && !at_bot: begin
                    cnt_nxt = counter - 1'b1;
                end
                !p_zero && !is_edge && !dir_down && at_top: begin
                    dir_nxt = 1'b1;
                    cnt_nxt = period_act - 1'b1;
                end
                default: begin
                    cnt_nxt = counter + 1'b1;
                end
            endcase
        end
        // A mode switch restarts the waveform from a clean up-count.
        if (boundary && (mode_nxt != mode_act)) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            counter    <= '0;
            dir_down   <= 1'b0;
            mode_act   <= PWM_EDGE;
            period_shd <= '1;
            period_act <= '1;
            period_end <= 1'b0;
        end else begin
            counter    <= cnt_nxt;
            dir_down   <= dir_nxt;
            period_end <= boundary;
            if (period_wr) begin
                period_shd <= period_data;
            end
            if (boundary) begin
                period_act <= period_shd;
                mode_act   <= mode_nxt;
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: write-edge detect, double-buffered compares and
// per-channel comparators around one shared timebase.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 8,
    localparam int ADDR_W   = $clog2(CHANNELS + 1)
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                clk_in,
    input  logic                use_sys,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                center,
    input  logic [CHANNELS-1:0] ena,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_end
);

    localparam int PERIOD_SLOT = period_addr(CHANNELS);

    logic                wr_q;
    logic                wr_edge;
    logic                tick;
    logic                period_wr;
    logic                boundary;
    logic [WIDTH-1:0]    counter;
    logic [CHANNELS-1:0] pwm_nxt;

    assign wr_edge   = wr & ~wr_q;
    assign tick      = use_sys | clk_in;
    assign period_wr = wr_edge &&
                       (wr_addr == ADDR_W'(PERIOD_SLOT));

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            wr_q <= 1'b0;
        end else begin
            wr_q <= wr;
        end
    end

    pwm_timebase #(
        .WIDTH(WIDTH)
    ) u_timebase (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .center     (center),
        .period_wr  (period_wr),
        .period_data(wr_data),
        .counter    (counter),
        .boundary   (boundary),
        .period_end (period_end)
    );

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [WIDTH-1:0] shd;
        logic [WIDTH-1:0] act;
        logic             sel;

        assign sel = wr_edge && (wr_addr == ADDR_W'(n));

        always_ff @(posedge sys_clk) begin
            if (!rst_n) begin
                shd <= '0;
                act <= '0;
            end else begin
                if (sel) begin
                    shd <= wr_data;
                end
                if (boundary) begin
                    act <= shd;
                end
            end
        end

        // Compare above period naturally yields a constant-high output.
        assign pwm_nxt[n] = ena[n] && (counter < act);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: expected windows and samples are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_pwm_multi;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int AW = 3;

    logic          sys_clk = 1'b0;
    logic          rst_n;
    logic          clk_in = 1'b0;
    logic          use_sys;
    logic          wr;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          center;
    logic [CH-1:0] ena;
    logic [CH-1:0] pwm_out;
    logic          period_end;

    pwm_multi #(
        .CHANNELS(CH),
        .WIDTH   (W)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .clk_in    (clk_in),
        .use_sys   (use_sys),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .center    (center),
        .ena       (ena),
        .pwm_out   (pwm_out),
        .period_end(period_end)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) clk_in = (cyc % 4 == 0);

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int                   after;
        int                   len;
        logic [CH-1:0][15:0]  hi;
    } win_t;

    typedef struct {
        int            cyc;
        logic [CH-1:0] mask;
        logic [CH-1:0] pwm;
        logic          pe_chk;
        logic          pe;
    } smp_t;

    win_t win_q[$];
    smp_t smp_q[$];
    win_t w_cur;
    smp_t s_cur;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d",
                     name, cyc, act, exp);
        end
    endtask

    task automatic push_win(input int after, input int len,
                            input int h0, input int h1,
                            input int h2, input int h3);
        win_t e;
        e.after = after;
        e.len   = len;
        e.hi[0] = 16'(h0);
        e.hi[1] = 16'(h1);
        e.hi[2] = 16'(h2);
        e.hi[3] = 16'(h3);
        win_q.push_back(e);
    endtask

    task automatic push_smp(input int c, input logic [CH-1:0] m,
                            input logic [CH-1:0] p,
                            input logic pc, input logic pv);
        smp_t e;
        e.cyc    = c;
        e.mask   = m;
        e.pwm    = p;
        e.pe_chk = pc;
        e.pe     = pv;
        smp_q.push_back(e);
    endtask

    int win_len;
    int win_start;
    int hi_cnt [CH];

    always @(negedge sys_clk) begin
        if (rst_n !== 1'b1) begin
            win_len   = 0;
            win_start = cyc + 1;
            for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
        end else begin
            while (smp_q.size() > 0 && smp_q[0].cyc <= cyc) begin
                s_cur = smp_q.pop_front();
                check("smp_cycle", s_cur.cyc, cyc);
                if (s_cur.mask != '0)
                    check("smp_pwm", int'(pwm_out & s_cur.mask),
                          int'(s_cur.pwm));
                if (s_cur.pe_chk)
                    check("smp_period_end", int'(period_end),
                          int'(s_cur.pe));
            end
            win_len++;
            for (int i = 0; i < CH; i++)
                if (pwm_out[i]) hi_cnt[i]++;
            if (period_end) begin
                if (win_q.size() > 0 && win_start > win_q[0].after) begin
                    w_cur = win_q.pop_front();
                    check("win_len", win_len, w_cur.len);
                    for (int i = 0; i < CH; i++)
                        check($sformatf("win_high_ch%0d", i),
                              hi_cnt[i], int'(w_cur.hi[i]));
                end
                win_len   = 0;
                win_start = cyc + 1;
                for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr      = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge sys_clk);
        wr = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic wait_pe(output int pc);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!period_end && n < 700);
        check("period_end_seen", int'(period_end), 1);
        pc = cyc;
    endtask

    task automatic settle_pe(output int pc);
        repeat (2) @(negedge sys_clk);
        wait_pe(pc);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    int p;

    initial begin
        rst_n   = 1'b0;
        use_sys = 1'b1;
        wr      = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        center  = 1'b0;
        ena     = 4'hF;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++)
            push_smp(cyc + k, 4'hF, 4'h0, 1'b1, 1'b0);

        wait_pe(p);
        push_win(p, 256, 0, 0, 0, 0);
        do_write(3'd4, 8'd9);
        do_write(3'd0, 8'd3);
        do_write(3'd1, 8'd10);
        do_write(3'd2, 8'd0);

        wait_pe(p);
        push_win(p, 10, 3, 10, 0, 0);
        wait_pe(p);
        push_win(p, 10, 3, 10, 0, 0);
        repeat (5) @(negedge sys_clk);
        do_write(3'd0, 8'd7);
        settle_pe(p);
        push_win(p, 10, 7, 10, 0, 0);
        wait_pe(p);

        repeat (3) @(negedge sys_clk);
        ena[1] = 1'b0;
        push_smp(cyc + 1, 4'b0010, 4'b0000, 1'b0, 1'b0);
        repeat (2) @(negedge sys_clk);
        ena[1] = 1'b1;

        wait_pe(p);
        do_write(3'd4, 8'd4);
        do_write(3'd0, 8'd2);
        center = 1'b1;
        settle_pe(p);
        push_win(p, 9, 4, 9, 0, 0);
        push_win(p, 8, 3, 8, 0, 0);
        push_win(p, 8, 3, 8, 0, 0);
        repeat (3) wait_pe(p);

        use_sys = 1'b0;
        do_write(3'd4, 8'd2);
        wr      = 1'b1;
        wr_addr = 3'd0;
        wr_data = 8'd1;
        @(negedge sys_clk);
        wr_data = 8'd5;
        @(negedge sys_clk);
        wr_data = 8'd6;
        @(negedge sys_clk);
        wr_data = 8'd7;
        @(negedge sys_clk);
        wr_data = 8'd8;
        @(negedge sys_clk);
        wr     = 1'b0;
        center = 1'b0;
        settle_pe(p);
        push_win(p, 12, 4, 12, 0, 0);
        push_win(p, 12, 4, 12, 0, 0);
        repeat (2) wait_pe(p);

        use_sys = 1'b1;
        do_write(3'd4, 8'd0);
        settle_pe(p);
        for (int k = 1; k <= 4; k++)
            push_smp(p + k, 4'hF, 4'b0011, 1'b1, 1'b1);
        repeat (8) @(negedge sys_clk);

        check("win_queue_left", win_q.size(), 0);
        check("smp_queue_left", smp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
